// File: rtl/pll_cfg_writer.sv
// PLL reconfiguration writer: pushes a MODE/M/N/C/K/START register sequence to
// the reconfig slave, then waits for the PLL to relock or time out.
module pll_cfg_writer #(
   parameter int unsigned LOCK_TIMEOUT = 1000000,
   parameter int unsigned C_SEL        = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_req,
   input  logic [17:0] cfg_m,
   input  logic [17:0] cfg_n,
   input  logic [17:0] cfg_c,
   input  logic [31:0] cfg_k,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   input  logic        mgmt_waitrequest,
   input  logic        locked,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int CNT_W = ($clog2(LOCK_TIMEOUT + 1) > 20) ? $clog2(LOCK_TIMEOUT + 1) : 20;
   localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] MIN_LOCK_CNT = CNT_W'(16);
   localparam logic [4:0]       C_FIELD      = 5'(C_SEL);

   localparam logic [5:0] ADDR_MODE  = 6'h00;
   localparam logic [5:0] ADDR_M     = 6'h04;
   localparam logic [5:0] ADDR_N     = 6'h03;
   localparam logic [5:0] ADDR_C     = 6'h05;
   localparam logic [5:0] ADDR_K     = 6'h07;
   localparam logic [5:0] ADDR_START = 6'h02;

   typedef enum logic [2:0] {
      IDLE, W_MODE, W_M, W_N, W_C, W_K, W_START, WAIT_LOCK
   } state_t;

   state_t           state_reg;
   logic [17:0]      m_reg;
   logic [17:0]      n_reg;
   logic [17:0]      c_reg;
   logic [31:0]      k_reg;
   logic             lock_meta_reg;
   logic             lock_s;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   state_t           wr_state_next;
   logic [5:0]       wr_addr_next;
   logic [31:0]      wr_data_next;

   // locked comes from the PLL's own domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_reg <= 1'b0;
         lock_s        <= 1'b0;
      end else begin
         lock_meta_reg <= locked;
         lock_s        <= lock_meta_reg;
      end
   end

   assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

   // Address/data of the write that follows the one currently on the bus.
   always_comb begin
      wr_state_next = state_reg;
      wr_addr_next  = ADDR_MODE;
      wr_data_next  = 32'h0;
      case (state_reg)
         W_MODE: begin
            wr_state_next = W_M;
            wr_addr_next  = ADDR_M;
            wr_data_next  = {14'b0, m_reg};
         end
         W_M: begin
            wr_state_next = W_N;
            wr_addr_next  = ADDR_N;
            wr_data_next  = {14'b0, n_reg};
         end
         W_N: begin
            wr_state_next = W_C;
            wr_addr_next  = ADDR_C;
            wr_data_next  = {9'b0, C_FIELD, c_reg};
         end
         W_C: begin
            wr_state_next = W_K;
            wr_addr_next  = ADDR_K;
            wr_data_next  = k_reg;
         end
         W_K: begin
            wr_state_next = W_START;
            wr_addr_next  = ADDR_START;
            wr_data_next  = 32'h0;
         end
         W_START: begin
            wr_state_next = WAIT_LOCK;
         end
         default: begin
            wr_state_next = state_reg;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         m_reg          <= '0;
         n_reg          <= '0;
         c_reg          <= '0;
         k_reg          <= '0;
         cnt_reg        <= '0;
         mgmt_write     <= 1'b0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cfg_req) begin
                  m_reg          <= cfg_m;
                  n_reg          <= cfg_n;
                  c_reg          <= cfg_c;
                  k_reg          <= cfg_k;
                  state_reg      <= W_MODE;
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= ADDR_MODE;
                  mgmt_writedata <= 32'h0;
                  busy           <= 1'b1;
               end
            end
            W_MODE, W_M, W_N, W_C, W_K: begin
               if (!mgmt_waitrequest) begin
                  state_reg      <= wr_state_next;
                  mgmt_address   <= wr_addr_next;
                  mgmt_writedata <= wr_data_next;
               end
            end
            W_START: begin
               if (!mgmt_waitrequest) begin
                  state_reg      <= WAIT_LOCK;
                  mgmt_write     <= 1'b0;
                  mgmt_address   <= '0;
                  mgmt_writedata <= '0;
                  cnt_reg        <= '0;
               end
            end
            WAIT_LOCK: begin
               cnt_reg <= cnt_next;
               // Early lock is ignored: the PLL may still report the old lock.
               if (lock_s && (cnt_next >= MIN_LOCK_CNT)) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end else if (!lock_s && (cnt_next >= TIMEOUT_CNT)) begin
                  error     <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Randomised self-checking bench for pll_cfg_writer: write sequence, stalls,
// relock timing, timeout, ignored requests and reset during a write.
module tb_pll_cfg_writer;

   localparam int         LT   = 200;
   localparam logic [4:0] CSEL = 5'd21;
   localparam int         RUN_BUDGET = 1000;

   logic        clk;
   logic        rst_n;
   logic        cfg_req;
   logic [17:0] cfg_m;
   logic [17:0] cfg_n;
   logic [17:0] cfg_c;
   logic [31:0] cfg_k;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_write;
   logic        mgmt_waitrequest;
   logic        locked;
   logic        busy;
   logic        done;
   logic        error;

   pll_cfg_writer #(.LOCK_TIMEOUT(LT), .C_SEL(21)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg_req          (cfg_req),
      .cfg_m            (cfg_m),
      .cfg_n            (cfg_n),
      .cfg_c            (cfg_c),
      .cfg_k            (cfg_k),
      .mgmt_address     (mgmt_address),
      .mgmt_writedata   (mgmt_writedata),
      .mgmt_write       (mgmt_write),
      .mgmt_waitrequest (mgmt_waitrequest),
      .locked           (locked),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   // Results of the last transaction (sample indices count negedges after the request).
   int          nw;
   logic [5:0]  wa [8];
   logic [31:0] wd [8];
   int          ws [8];
   int          vis [8];
   int          start_s, obs_done, obs_err, exp_done, exp_err;
   int          busy_bad, stable_bad, both_bad;
   bit          pulsed_g;

   function automatic logic [5:0] exp_addr(input int i);
      case (i)
         0: return 6'h00;
         1: return 6'h04;
         2: return 6'h03;
         3: return 6'h05;
         4: return 6'h07;
         default: return 6'h02;
      endcase
   endfunction

   function automatic logic [31:0] exp_data(input int i, input logic [17:0] m, input logic [17:0] n,
                                            input logic [17:0] c, input logic [31:0] k);
      case (i)
         1: return {14'b0, m};
         2: return {14'b0, n};
         3: return {9'b0, CSEL, c};
         4: return k;
         default: return 32'h0;
      endcase
   endfunction

   // Drives one request; locked stays high (stale) until the START write completes,
   // then is low for drop_len samples, then takes lock_after.
   task automatic run_xfer(input logic [17:0] m, input logic [17:0] n, input logic [17:0] c,
                           input logic [31:0] k, input int stall_pct, input int stall_addr,
                           input int stall_len, input int drop_len, input bit lock_after,
                           input bit req_again);
      logic [5:0]  pa;
      logic [31:0] pd;
      bit          prev_stall;
      int          stall_left;
      int          cur_vis;
      bit          lv;
      nw = 0; start_s = -1; obs_done = -1; obs_err = -1;
      busy_bad = 0; stable_bad = 0; both_bad = 0; pulsed_g = 0;
      prev_stall = 0; stall_left = stall_len; cur_vis = 0; pa = '0; pd = '0;
      @(negedge clk);
      #1;
      cfg_req = 1'b1; cfg_m = m; cfg_n = n; cfg_c = c; cfg_k = k;
      locked = 1'b1; mgmt_waitrequest = 1'b0;
      for (int s = 1; s <= RUN_BUDGET && obs_done < 0 && obs_err < 0; s++) begin
         @(negedge clk);
         if (done) obs_done = s;
         if (error) obs_err = s;
         if (done && error) both_bad++;
         if (obs_done < 0 && obs_err < 0 && !busy) busy_bad++;
         if ((obs_done >= 0 || obs_err >= 0) && busy) busy_bad++;
         if (mgmt_write && prev_stall && (mgmt_address !== pa || mgmt_writedata !== pd)) stable_bad++;
         if (mgmt_write) cur_vis++;
         #1;
         cfg_req = 1'b0;
         if (s == 1) begin
            cfg_m = 18'($urandom); cfg_n = 18'($urandom); cfg_c = 18'($urandom); cfg_k = $urandom;
         end
         if (req_again && !pulsed_g && mgmt_write && mgmt_address == 6'h03) begin
            cfg_req = 1'b1;
            pulsed_g = 1'b1;
         end
         if (stall_addr >= 0 && mgmt_write && mgmt_address == stall_addr[5:0] && stall_left > 0) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
         end else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
            mgmt_waitrequest = 1'b1;
         end else begin
            mgmt_waitrequest = 1'b0;
         end
         if (start_s >= 0) locked = (s <= start_s + drop_len) ? 1'b0 : lock_after;
         if (mgmt_write && !mgmt_waitrequest) begin
            if (nw < 8) begin
               wa[nw] = mgmt_address; wd[nw] = mgmt_writedata; ws[nw] = s; vis[nw] = cur_vis;
            end
            nw++;
            cur_vis = 0;
            if (mgmt_address == 6'h02 && start_s < 0) start_s = s;
         end
         prev_stall = mgmt_write && mgmt_waitrequest;
         pa = mgmt_address;
         pd = mgmt_writedata;
      end
      mgmt_waitrequest = 1'b0;
      // Reference: lock seen through two flops, done once >=16 cycles in WAIT_LOCK,
      // error at LT cycles; WAIT_LOCK cycle j is sample start_s+1+j.
      exp_done = -1; exp_err = -1;
      if (start_s >= 0) begin
         for (int j = 16; j <= LT; j++) begin
            lv = (j - 2 <= drop_len) ? 1'b0 : lock_after;
            if (lv) begin
               exp_done = start_s + 1 + j;
               break;
            end
            if (j == LT) exp_err = start_s + 1 + LT;
         end
      end
      $display("xfer m=%05h n=%05h c=%05h k=%08h writes=%0d start@%0d done@%0d error@%0d",
               m, n, c, k, nw, start_s, obs_done, obs_err);
   endtask

   task automatic test_reset();
      int stray = 0;
      rst_n = 1'b0; cfg_req = 1'b1; locked = 1'b1; mgmt_waitrequest = 1'b0;
      cfg_m = '1; cfg_n = '1; cfg_c = '1; cfg_k = '1;
      #2;
      checks++;
      if ({mgmt_write, busy, done, error, mgmt_address, mgmt_writedata} !== '0)
         begin errors++; $display("FAIL reset_async outputs=%h required 0",
            {mgmt_write, busy, done, error, mgmt_address, mgmt_writedata}); end
      repeat (3) @(negedge clk);
      checks++;
      if ({mgmt_write, busy, done, error, mgmt_address, mgmt_writedata} !== '0)
         begin errors++; $display("FAIL reset_held outputs=%h required 0",
            {mgmt_write, busy, done, error, mgmt_address, mgmt_writedata}); end
      #1; cfg_req = 1'b0; rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (mgmt_write || busy || done || error) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL idle_after_reset active=%0d required 0", stray); end
   endtask

   task automatic test_nominal();
      run_xfer(18'h00808, 18'h10000, 18'h00404, 32'h8000_0000, 0, -1, 0, 100, 1'b1, 1'b0);
      checks++;
      if (nw != 6) begin errors++; $display("FAIL nominal_count writes=%0d required 6", nw); end
      for (int i = 0; i < 6 && i < nw; i++) begin
         checks++;
         if (wa[i] !== exp_addr(i) || wd[i] !== exp_data(i, 18'h00808, 18'h10000, 18'h00404, 32'h8000_0000)
             || ws[i] != i + 1)
            begin errors++; $display("FAIL nominal_write%0d got %h:%h@%0d required %h:%h@%0d", i, wa[i], wd[i],
               ws[i], exp_addr(i), exp_data(i, 18'h00808, 18'h10000, 18'h00404, 32'h8000_0000), i + 1); end
      end
      checks++;
      if (obs_done != exp_done || obs_done - start_s != 104)
         begin errors++; $display("FAIL nominal_done at=%0d required %0d", obs_done, exp_done); end
      checks++;
      if (obs_err != -1 || busy_bad != 0 || both_bad != 0)
         begin errors++; $display("FAIL nominal_flags err=%0d busy_bad=%0d both=%0d required -1/0/0",
            obs_err, busy_bad, both_bad); end
   endtask

   task automatic test_stall();
      logic [17:0] m = 18'($urandom), n = 18'($urandom), c = 18'($urandom);
      logic [31:0] k = $urandom;
      run_xfer(m, n, c, k, 0, 4, 5, 20, 1'b1, 1'b0);
      checks++;
      if (nw != 6 || vis[1] != 6 || ws[1] != 7 || ws[2] != 8)
         begin errors++; $display("FAIL stall_timing writes=%0d m_vis=%0d m_at=%0d n_at=%0d required 6/6/7/8",
            nw, vis[1], ws[1], ws[2]); end
      for (int i = 0; i < 6 && i < nw; i++) begin
         checks++;
         if (wa[i] !== exp_addr(i) || wd[i] !== exp_data(i, m, n, c, k))
            begin errors++; $display("FAIL stall_write%0d got %h:%h required %h:%h", i, wa[i], wd[i],
               exp_addr(i), exp_data(i, m, n, c, k)); end
      end
      checks++;
      if (stable_bad != 0) begin errors++; $display("FAIL stall_stable changes=%0d required 0", stable_bad); end
      checks++;
      if (obs_done != exp_done) begin errors++; $display("FAIL stall_done at=%0d required %0d", obs_done, exp_done); end
   endtask

   task automatic test_timeout();
      run_xfer(18'($urandom), 18'($urandom), 18'($urandom), $urandom, 0, -1, 0, 100000, 1'b0, 1'b0);
      checks++;
      if (obs_err != exp_err || obs_err - start_s != LT + 1)
         begin errors++; $display("FAIL timeout_error at=%0d required %0d", obs_err, start_s + LT + 1); end
      checks++;
      if (obs_done != -1 || busy_bad != 0)
         begin errors++; $display("FAIL timeout_flags done=%0d busy_bad=%0d required -1/0", obs_done, busy_bad); end
   endtask

   task automatic test_req_ignored();
      logic [17:0] m = 18'($urandom), n = 18'($urandom), c = 18'($urandom);
      logic [31:0] k = $urandom;
      run_xfer(m, n, c, k, 10, -1, 0, 30, 1'b1, 1'b1);
      checks++;
      if (!pulsed_g || nw != 6)
         begin errors++; $display("FAIL reqign_count pulsed=%0d writes=%0d required 1/6", pulsed_g, nw); end
      for (int i = 0; i < 6 && i < nw; i++) begin
         checks++;
         if (wa[i] !== exp_addr(i) || wd[i] !== exp_data(i, m, n, c, k))
            begin errors++; $display("FAIL reqign_write%0d got %h:%h required %h:%h", i, wa[i], wd[i],
               exp_addr(i), exp_data(i, m, n, c, k)); end
      end
      checks++;
      if (obs_done != exp_done) begin errors++; $display("FAIL reqign_done at=%0d required %0d", obs_done, exp_done); end
   endtask

   task automatic test_stale_lock();
      run_xfer(18'($urandom), 18'($urandom), 18'($urandom), $urandom, 0, -1, 0, 0, 1'b1, 1'b0);
      checks++;
      if (obs_done != exp_done || obs_done - start_s != 17)
         begin errors++; $display("FAIL stale_done at=%0d required %0d", obs_done, start_s + 17); end
   endtask

   task automatic test_reset_mid_write();
      int seen = 0;
      int stray = 0;
      @(negedge clk);
      #1;
      cfg_req = 1'b1; cfg_m = 18'($urandom); cfg_n = 18'($urandom); cfg_c = 18'($urandom); cfg_k = $urandom;
      mgmt_waitrequest = 1'b0; locked = 1'b1;
      for (int s = 0; s < 40 && seen < 3; s++) begin
         @(negedge clk);
         #1;
         cfg_req = 1'b0;
         if (mgmt_write && mgmt_address == 6'h05) begin
            mgmt_waitrequest = 1'b1;
            seen++;
         end
      end
      checks++;
      if (seen != 3) begin errors++; $display("FAIL rstmid_reach_wc stalls=%0d required 3", seen); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (mgmt_write !== 1'b0 || busy !== 1'b0 || mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0)
         begin errors++; $display("FAIL rstmid_async write=%b busy=%b addr=%h data=%h required 0",
            mgmt_write, busy, mgmt_address, mgmt_writedata); end
      @(negedge clk);
      #1;
      rst_n = 1'b1; mgmt_waitrequest = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (mgmt_write || busy || done || error) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL rstmid_idle active=%0d required 0", stray); end
      run_xfer(18'($urandom), 18'($urandom), 18'($urandom), $urandom, 0, -1, 0, 40, 1'b1, 1'b0);
      checks++;
      if (nw != 6 || wa[0] !== 6'h00 || ws[0] != 1 || obs_done != exp_done)
         begin errors++; $display("FAIL rstmid_restart writes=%0d first=%h@%0d done=%0d required 6/00@1/%0d",
            nw, wa[0], ws[0], obs_done, exp_done); end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         run_xfer(18'($urandom), 18'($urandom), 18'($urandom), $urandom, 0, -1, 0,
                  int'($urandom_range(40)), 1'b1, 1'b0);
         checks++;
         if (nw != 6 || wa[0] !== 6'h00 || ws[0] != 1 || obs_done != exp_done || busy_bad != 0)
            begin errors++; $display("FAIL b2b_run%0d writes=%0d first@%0d done=%0d busy_bad=%0d required 6/1/%0d/0",
               r, nw, ws[0], obs_done, busy_bad, exp_done); end
      end
   endtask

   task automatic test_random();
      logic [17:0] m, n, c;
      logic [31:0] k;
      int          dl;
      bit          la;
      for (int r = 0; r < 12; r++) begin
         m = 18'($urandom); n = 18'($urandom); c = 18'($urandom); k = $urandom;
         dl = int'($urandom_range(150));
         la = ($urandom_range(4) != 0);
         run_xfer(m, n, c, k, int'($urandom_range(40)), -1, 0, dl, la, 1'b0);
         checks++;
         if (nw != 6) begin errors++; $display("FAIL rand%0d_count writes=%0d required 6", r, nw); end
         for (int i = 0; i < 6 && i < nw; i++) begin
            checks++;
            if (wa[i] !== exp_addr(i) || wd[i] !== exp_data(i, m, n, c, k))
               begin errors++; $display("FAIL rand%0d_write%0d got %h:%h required %h:%h", r, i, wa[i], wd[i],
                  exp_addr(i), exp_data(i, m, n, c, k)); end
         end
         checks++;
         if (obs_done != exp_done || obs_err != exp_err)
            begin errors++; $display("FAIL rand%0d_outcome done=%0d err=%0d required %0d/%0d", r,
               obs_done, obs_err, exp_done, exp_err); end
         checks++;
         if (busy_bad != 0 || stable_bad != 0 || both_bad != 0)
            begin errors++; $display("FAIL rand%0d_flags busy_bad=%0d stable_bad=%0d both=%0d required 0",
               r, busy_bad, stable_bad, both_bad); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_nominal();
      test_stall();
      test_timeout();
      test_req_ignored();
      test_stale_lock();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
